// File: rtl/gps_ack_search_if.sv
// Request/result bundle for the GPS C/A snapshot acquisition engine.
// The master side is the ADC sampler plus firmware; the slave side is the search engine.
interface gps_ack_search_if #(
  parameter int DEPTH = 1023,
  parameter int NCO_W = 32
);
  localparam int ACC_W = $clog2(4 * DEPTH + 1) + 1;

  logic             adc_clk;
  logic             i_sample;
  logic             q_sample;
  logic             start;
  logic [5:0]       satellite;
  logic [NCO_W-1:0] doppler;
  logic             busy;
  logic             done;
  logic             sat_err;
  logic [ACC_W-1:0] peak_mag;
  logic [9:0]       peak_phase;

  modport master (
    output adc_clk, i_sample, q_sample, start, satellite, doppler,
    input  busy, done, sat_err, peak_mag, peak_phase
  );

  modport slave (
    input  adc_clk, i_sample, q_sample, start, satellite, doppler,
    output busy, done, sat_err, peak_mag, peak_phase
  );
endinterface

// File: rtl/gps_ack_search.sv
// Snapshot serial-search acquisition for GPS L1 C/A with a 1-bit I/Q front end:
// capture DEPTH samples, then correlate N_PHASES code phases against one Doppler bin.
module gps_ack_search #(
  parameter int DEPTH    = 1023,
  parameter int N_PHASES = 1023,
  parameter int NCO_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  gps_ack_search_if.slave bus
);
  localparam int ACC_W = $clog2(4 * DEPTH + 1) + 1;
  localparam int K_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_LOAD,
    S_INTEG,
    S_DUMP,
    S_FINISH
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]              r_sync0;
  logic                    r_sync1;
  logic                    w_rise;

  logic                    r_busy;
  logic                    r_done;
  logic                    r_sat_err;
  logic [3:0]              r_t1;
  logic [3:0]              r_t2;
  logic [NCO_W-1:0]        r_doppler;

  logic [K_W-1:0]          r_cap_idx;
  logic [K_W-1:0]          r_k;
  logic [9:0]              r_phase;

  logic [10:1]             r_g1;
  logic [10:1]             r_g2;
  logic [10:1]             r_start_g1;
  logic [10:1]             r_start_g2;

  logic [NCO_W-1:0]        r_ph;
  logic signed [ACC_W-1:0] r_acc_i;
  logic signed [ACC_W-1:0] r_acc_q;
  logic [ACC_W-1:0]        r_peak_mag;
  logic [9:0]              r_peak_phase;

  logic [1:0]              r_buf [0:DEPTH-1];
  logic [1:0]              r_rd;
  logic [K_W-1:0]          w_rd_addr;

  logic [7:0]              w_taps;
  logic                    w_prn_ok;
  logic                    w_start_ok;
  logic                    w_cap_last;
  logic                    w_k_last;
  logic                    w_phase_last;
  logic                    w_chip;
  logic                    w_c;
  logic                    w_s;
  logic signed [ACC_W-1:0] w_di;
  logic signed [ACC_W-1:0] w_dq;
  logic [ACC_W-1:0]        w_abs_i;
  logic [ACC_W-1:0]        w_abs_q;
  logic [ACC_W-1:0]        w_mag;

  // G2 output tap pair for each PRN; zero marks an invalid PRN.
  function automatic logic [7:0] prn_taps(input logic [5:0] prn);
    case (prn)
      6'd1:  prn_taps = {4'd2, 4'd6};
      6'd2:  prn_taps = {4'd3, 4'd7};
      6'd3:  prn_taps = {4'd4, 4'd8};
      6'd4:  prn_taps = {4'd5, 4'd9};
      6'd5:  prn_taps = {4'd1, 4'd9};
      6'd6:  prn_taps = {4'd2, 4'd10};
      6'd7:  prn_taps = {4'd1, 4'd8};
      6'd8:  prn_taps = {4'd2, 4'd9};
      6'd9:  prn_taps = {4'd3, 4'd10};
      6'd10: prn_taps = {4'd2, 4'd3};
      6'd11: prn_taps = {4'd3, 4'd4};
      6'd12: prn_taps = {4'd5, 4'd6};
      6'd13: prn_taps = {4'd6, 4'd7};
      6'd14: prn_taps = {4'd7, 4'd8};
      6'd15: prn_taps = {4'd8, 4'd9};
      6'd16: prn_taps = {4'd9, 4'd10};
      6'd17: prn_taps = {4'd1, 4'd4};
      6'd18: prn_taps = {4'd2, 4'd5};
      6'd19: prn_taps = {4'd3, 4'd6};
      6'd20: prn_taps = {4'd4, 4'd7};
      6'd21: prn_taps = {4'd5, 4'd8};
      6'd22: prn_taps = {4'd6, 4'd9};
      6'd23: prn_taps = {4'd1, 4'd3};
      6'd24: prn_taps = {4'd4, 4'd6};
      6'd25: prn_taps = {4'd5, 4'd7};
      6'd26: prn_taps = {4'd6, 4'd8};
      6'd27: prn_taps = {4'd7, 4'd9};
      6'd28: prn_taps = {4'd8, 4'd10};
      6'd29: prn_taps = {4'd1, 4'd6};
      6'd30: prn_taps = {4'd2, 4'd7};
      6'd31: prn_taps = {4'd3, 4'd8};
      6'd32: prn_taps = {4'd4, 4'd9};
      default: prn_taps = 8'd0;
    endcase
  endfunction

  function automatic logic [10:1] g1_step(input logic [10:1] g);
    g1_step = {g[9:1], g[3] ^ g[10]};
  endfunction

  function automatic logic [10:1] g2_step(input logic [10:1] g);
    g2_step = {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
  endfunction

  function automatic logic signed [ACC_W-1:0] sgn(input logic b);
    sgn = b ? {ACC_W{1'b1}} : ACC_W'(1);
  endfunction

  assign w_rise       = ~r_sync1 & r_sync0[0];
  assign w_taps       = prn_taps(bus.satellite);
  assign w_prn_ok     = (w_taps != 8'd0);
  assign w_start_ok   = bus.start & ~r_busy & (r_state == S_IDLE);
  assign w_cap_last   = w_rise && (r_cap_idx == K_W'(DEPTH - 1));
  assign w_k_last     = (r_k == K_W'(DEPTH - 1));
  assign w_phase_last = (r_phase == 10'(N_PHASES - 1));

  // Carrier wipe-off: quadrant of the NCO phase gives cos/sin sign bits.
  assign w_chip = r_g1[10] ^ r_g2[r_t1] ^ r_g2[r_t2];
  assign w_c    = r_ph[NCO_W-1] ^ r_ph[NCO_W-2];
  assign w_s    = r_ph[NCO_W-1];
  assign w_di   = sgn(r_rd[0] ^ w_c ^ w_chip) + sgn(r_rd[1] ^ w_s ^ w_chip);
  assign w_dq   = sgn(r_rd[1] ^ w_c ^ w_chip) - sgn(r_rd[0] ^ w_s ^ w_chip);

  assign w_abs_i = r_acc_i[ACC_W-1] ? $unsigned(-r_acc_i) : $unsigned(r_acc_i);
  assign w_abs_q = r_acc_q[ACC_W-1] ? $unsigned(-r_acc_q) : $unsigned(r_acc_q);
  assign w_mag   = w_abs_i + w_abs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_addr    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = w_prn_ok ? S_CAPTURE : S_FINISH;
        end
      end
      S_CAPTURE: begin
        if (w_cap_last) begin
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = S_INTEG;
      end
      S_INTEG: begin
        // Prefetch the next sample so the registered read stays one cycle ahead.
        if (!w_k_last) begin
          w_rd_addr = r_k + K_W'(1);
        end
        if (w_k_last) begin
          w_state_next = S_DUMP;
        end
      end
      S_DUMP: begin
        w_state_next = w_phase_last ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sample store is not reset: a search always writes all DEPTH entries before reading.
  always_ff @(posedge clk) begin
    if (r_state == S_CAPTURE && w_rise) begin
      r_buf[r_cap_idx] <= r_sync0[2:1];
    end
    r_rd <= r_buf[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0      <= '0;
      r_sync1      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_sat_err    <= 1'b0;
      r_t1         <= '0;
      r_t2         <= '0;
      r_doppler    <= '0;
      r_cap_idx    <= '0;
      r_k          <= '0;
      r_phase      <= '0;
      r_g1         <= '0;
      r_g2         <= '0;
      r_start_g1   <= '0;
      r_start_g2   <= '0;
      r_ph         <= '0;
      r_acc_i      <= '0;
      r_acc_q      <= '0;
      r_peak_mag   <= '0;
      r_peak_phase <= '0;
    end else begin
      r_sync0 <= {bus.q_sample, bus.i_sample, bus.adc_clk};
      r_sync1 <= r_sync0[0];
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_busy     <= 1'b1;
            r_sat_err  <= ~w_prn_ok;
            r_t1       <= w_taps[7:4];
            r_t2       <= w_taps[3:0];
            r_doppler  <= bus.doppler;
            r_cap_idx  <= '0;
            r_phase    <= '0;
            r_start_g1 <= '1;
            r_start_g2 <= '1;
          end
        end
        S_CAPTURE: begin
          if (w_rise) begin
            r_cap_idx <= r_cap_idx + K_W'(1);
          end
        end
        S_LOAD: begin
          r_g1    <= r_start_g1;
          r_g2    <= r_start_g2;
          r_ph    <= '0;
          r_acc_i <= '0;
          r_acc_q <= '0;
          r_k     <= '0;
        end
        S_INTEG: begin
          r_acc_i <= r_acc_i + w_di;
          r_acc_q <= r_acc_q + w_dq;
          r_ph    <= r_ph + r_doppler;
          r_g1    <= g1_step(r_g1);
          r_g2    <= g2_step(r_g2);
          r_k     <= r_k + K_W'(1);
        end
        S_DUMP: begin
          // Strict compare keeps the earliest phase on ties.
          if (r_phase == 10'd0 || w_mag > r_peak_mag) begin
            r_peak_mag   <= w_mag;
            r_peak_phase <= r_phase;
          end
          r_start_g1 <= g1_step(r_start_g1);
          r_start_g2 <= g2_step(r_start_g2);
          if (!w_phase_last) begin
            r_phase <= r_phase + 10'd1;
          end
        end
        S_FINISH: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.sat_err    = r_sat_err;
  assign bus.peak_mag   = r_peak_mag;
  assign bus.peak_phase = r_peak_phase;

endmodule
